// File: rtl/wb_timer_pkg.sv
// wb_timer_pkg: register map and CTRL layout
// shared by wb_timer and wb_timer_chan
package wb_timer_pkg;

  localparam logic [1:0] R_CTRL    = 2'd0;
  localparam logic [1:0] R_RELOAD  = 2'd1;
  localparam logic [1:0] R_COUNT   = 2'd2;
  localparam logic [1:0] R_COMPARE = 2'd3;
  localparam logic [4:0] R_STATUS  = 5'd16;

  localparam int B_EN  = 0;
  localparam int B_AR  = 1;
  localparam int B_IE  = 2;
  localparam int P_LSB = 8;
  localparam int P_MSB = 15;

  typedef struct packed {
    logic [7:0] presc;
    logic       ie;
    logic       ar;
    logic       en;
  } ctrl_t;

  function automatic logic [31:0] ctrl_word(
    input ctrl_t c
  );
    logic [31:0] w;
    w              = '0;
    w[P_MSB:P_LSB] = c.presc;
    w[B_IE]        = c.ie;
    w[B_AR]        = c.ar;
    w[B_EN]        = c.en;
    return w;
  endfunction

  function automatic ctrl_t ctrl_dec(
    input logic [31:0] w
  );
    ctrl_t c;
    c.presc = w[P_MSB:P_LSB];
    c.ie    = w[B_IE];
    c.ar    = w[B_AR];
    c.en    = w[B_EN];
    return c;
  endfunction

endpackage

// File: rtl/wb_timer_chan.sv
// wb_timer_chan: one prescaled auto-reload down-counter
// COMPARE/PWM only exist when WB_TIMER_PWM_EN is defined
module wb_timer_chan
  import wb_timer_pkg::*;
#(
  parameter int CW = 24
) (
  input  logic             clk,
  input  logic             p_reset_n,
  input  logic             wr_ctrl,
  input  logic             wr_reload,
  input  logic             wr_count,
  input  logic             wr_cmp,
  input  logic [31:0]      wdata,
  output logic [3:0][31:0] rd_o,
  output logic             expire_o,
  output logic             irq_o,
  output logic             pwm_o
);

  ctrl_t         ctrl_q, ctrl_d;
  logic [7:0]    pre_q, pre_d;
  logic [CW-1:0] reload_q, reload_d;
  logic [CW-1:0] count_q, count_d;
  logic [CW-1:0] cmp_v;
  logic          irq_q, irq_d;
  logic          tick;
  logic          unused_wdata;

  assign tick     = ctrl_q.en
                  & (pre_q == ctrl_q.presc);
  assign expire_o = tick & (count_q == '0);
  assign irq_d    = expire_o & ctrl_q.ie;
  assign irq_o    = irq_q;
  assign unused_wdata = ^wdata;

  // prescale, count down, expire; bus writes win
  always_comb begin
    ctrl_d   = ctrl_q;
    pre_d    = pre_q;
    reload_d = reload_q;
    count_d  = count_q;
    if (ctrl_q.en) begin
      pre_d = tick ? 8'd0 : pre_q + 8'd1;
    end
    if (tick) begin
      if (count_q != '0) begin
        count_d = count_q - CW'(1);
      end else if (ctrl_q.ar) begin
        count_d = reload_q;
      end else begin
        ctrl_d.en = 1'b0;
      end
    end
    if (wr_ctrl) begin
      ctrl_d = ctrl_dec(wdata);
      if (wdata[B_EN] & ~ctrl_q.en) begin
        pre_d = 8'd0;
      end
    end
    if (wr_reload) begin
      reload_d = wdata[CW-1:0];
    end
    if (wr_count) begin
      count_d = wdata[CW-1:0];
      pre_d   = 8'd0;
    end
  end

  // channel state registers
  always_ff @(posedge clk or negedge p_reset_n) begin
    if (!p_reset_n) begin
      ctrl_q   <= '0;
      pre_q    <= '0;
      reload_q <= '0;
      count_q  <= '0;
      irq_q    <= 1'b0;
    end else begin
      ctrl_q   <= ctrl_d;
      pre_q    <= pre_d;
      reload_q <= reload_d;
      count_q  <= count_d;
      irq_q    <= irq_d;
    end
  end

`ifdef WB_TIMER_PWM_EN
  logic [CW-1:0] cmp_q, cmp_d;
  logic          pwm_q, pwm_d;

  assign pwm_d = ctrl_q.en
               & (count_q < cmp_q);
  assign cmp_v = cmp_q;
  assign pwm_o = pwm_q;

  // compare register update
  always_comb begin
    cmp_d = cmp_q;
    if (wr_cmp) begin
      cmp_d = wdata[CW-1:0];
    end
  end

  // compare and registered pwm output
  always_ff @(posedge clk or negedge p_reset_n) begin
    if (!p_reset_n) begin
      cmp_q <= '0;
      pwm_q <= 1'b0;
    end else begin
      cmp_q <= cmp_d;
      pwm_q <= pwm_d;
    end
  end
`else
  logic unused_cmp;

  assign cmp_v      = '0;
  assign pwm_o      = 1'b0;
  assign unused_cmp = wr_cmp;
`endif

  // zero-extended readback words
  always_comb begin
    rd_o                      = '0;
    rd_o[R_CTRL]              = ctrl_word(ctrl_q);
    rd_o[R_RELOAD][CW-1:0]    = reload_q;
    rd_o[R_COUNT][CW-1:0]     = count_q;
    rd_o[R_COMPARE][CW-1:0]   = cmp_v;
  end

endmodule

// File: rtl/wb_timer.sv
// wb_timer: Wishbone slave with CHANNELS timers
// PWM/COMPARE enabled by WB_TIMER_PWM_EN
module wb_timer
  import wb_timer_pkg::*;
#(
  parameter int          CHANNELS = 2,
  parameter int          CW       = 24,
  parameter logic [14:0] BASE     = 15'h0
) (
  input  logic                clk,
  input  logic                p_reset_n,
  input  logic [14:0]         adr_i,
  input  logic [31:0]         dat_i,
  output logic [31:0]         dat_o,
  input  logic                we_i,
  input  logic                stb_i,
  output logic                ack_o,
  output logic [CHANNELS-1:0] irq_o,
  output logic [CHANNELS-1:0] pwm_o
);

  logic                hit, acc, wr;
  logic [4:0]          a;
  logic                ack_q, ack_d;
  logic [31:0]         dat_q, dat_d;
  logic [31:0]         rdata;
  logic [CHANNELS-1:0] flag_q, flag_d;
  logic [CHANNELS-1:0] expire;
  logic [3:0][3:0][31:0] crd;

  assign a   = adr_i[4:0];
  assign hit = stb_i
             & (adr_i[14:5] == BASE[14:5]);
  assign acc = hit & ~ack_q;
  assign wr  = acc & we_i;

  for (genvar n = 0; n < 4; n++) begin : g_ch
    if (n < CHANNELS) begin : g_on
      logic sel;
      assign sel = wr & ~a[4]
                 & (a[3:2] == 2'(n));
      wb_timer_chan #(
        .CW(CW)
      ) u_chan (
        .clk      (clk),
        .p_reset_n(p_reset_n),
        .wr_ctrl  (sel & (a[1:0] == R_CTRL)),
        .wr_reload(sel & (a[1:0] == R_RELOAD)),
        .wr_count (sel & (a[1:0] == R_COUNT)),
        .wr_cmp   (sel & (a[1:0] == R_COMPARE)),
        .wdata    (dat_i),
        .rd_o     (crd[n]),
        .expire_o (expire[n]),
        .irq_o    (irq_o[n]),
        .pwm_o    (pwm_o[n])
      );
    end else begin : g_off
      assign crd[n] = '0;
    end
  end

  // read mux over channel words and STATUS
  always_comb begin
    rdata = '0;
    unique case (1'b1)
      (a == R_STATUS): rdata[CHANNELS-1:0] = flag_q;
      !a[4]:           rdata = crd[a[3:2]][a[1:0]];
      default: ;
    endcase
  end

  // ack pulse, read data, sticky expiry flags
  always_comb begin
    ack_d  = acc;
    dat_d  = acc ? rdata : '0;
    flag_d = flag_q;
    if (wr & (a == R_STATUS)) begin
      flag_d = flag_q & ~dat_i[CHANNELS-1:0];
    end
    flag_d = flag_d | expire;
  end

  // bus-side registers
  always_ff @(posedge clk or negedge p_reset_n) begin
    if (!p_reset_n) begin
      ack_q  <= 1'b0;
      dat_q  <= '0;
      flag_q <= '0;
    end else begin
      ack_q  <= ack_d;
      dat_q  <= dat_d;
      flag_q <= flag_d;
    end
  end

  assign ack_o = ack_q;
  assign dat_o = dat_q;

endmodule

// File: tb/tb_wb_timer.sv
// tb_wb_timer: random + directed bench for wb_timer
// reference model follows the register-level timer rules
module tb_wb_timer;

  localparam int CH = 2;
  localparam int CW = 24;
  localparam logic [14:0] BASE = 15'h0;
  localparam longint unsigned MASK =
    (64'd1 << CW) - 1;
`ifdef WB_TIMER_PWM_EN
  localparam bit PWM = 1'b1;
`else
  localparam bit PWM = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          p_reset_n;
  logic [14:0]   adr = '0;
  logic [31:0]   dat_i = '0;
  logic [31:0]   dat_o;
  logic          we = 1'b0;
  logic          stb = 1'b0;
  logic          ack;
  logic [CH-1:0] irq, pwm;

  wb_timer #(
    .CHANNELS(CH),
    .CW(CW),
    .BASE(BASE)
  ) dut (
    .clk(clk),
    .p_reset_n(p_reset_n),
    .adr_i(adr),
    .dat_i(dat_i),
    .dat_o(dat_o),
    .we_i(we),
    .stb_i(stb),
    .ack_o(ack),
    .irq_o(irq),
    .pwm_o(pwm)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  task automatic check(input string name,
                       input longint act,
                       input longint exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0h, want %0h",
               name, act, exp);
    end
  endtask

  typedef struct packed {
    logic        is_rd;
    logic [31:0] data;
  } exp_t;
  exp_t q[$];

  bit              m_en[CH], m_ar[CH], m_ie[CH];
  int unsigned     m_presc[CH], m_pre[CH];
  longint unsigned m_reload[CH], m_count[CH];
  longint unsigned m_cmp[CH];
  bit [CH-1:0]     m_flag, m_irq, m_pwm;
  bit              m_ack;
  int              irq_cnt[CH], pwm_cnt[CH];
  int              ack_cnt;

  task automatic model_reset();
    for (int n = 0; n < CH; n++) begin
      m_en[n] = 0; m_ar[n] = 0; m_ie[n] = 0;
      m_presc[n] = 0; m_pre[n] = 0;
      m_reload[n] = 0; m_count[n] = 0;
      m_cmp[n] = 0;
    end
    m_flag = '0; m_irq = '0; m_pwm = '0;
    m_ack = 0;
    q.delete();
  endtask

  function automatic logic [31:0] model_read(
    input int a
  );
    int n;
    if (a == 16) return 32'(m_flag);
    if (a >= 16) return 32'h0;
    n = a / 4;
    if (n >= CH) return 32'h0;
    case (a % 4)
      0: return (m_presc[n] << 8)
              | (32'(m_ie[n]) << 2)
              | (32'(m_ar[n]) << 1)
              | 32'(m_en[n]);
      1: return 32'(m_reload[n]);
      2: return 32'(m_count[n]);
      default: return PWM ? 32'(m_cmp[n]) : 0;
    endcase
  endfunction

  // one clock edge of the reference model
  task automatic model_step();
    bit acc, tk, ex;
    bit was_en[CH];
    bit [CH-1:0] exs, irq_n, pwm_n;
    int a, n;
    exp_t e;
    acc = stb && !m_ack
       && (adr[14:5] == BASE[14:5]);
    a = int'(adr[4:0]);
    if (acc) begin
      e.is_rd = !we;
      e.data  = model_read(a);
      q.push_back(e);
    end
    exs = '0; irq_n = '0; pwm_n = '0;
    for (int c = 0; c < CH; c++) begin
      was_en[c] = m_en[c];
      tk = m_en[c] && m_pre[c] == m_presc[c];
      ex = tk && m_count[c] == 0;
      exs[c]   = ex;
      irq_n[c] = ex && m_ie[c];
      pwm_n[c] = PWM && m_en[c]
              && m_count[c] < m_cmp[c];
      if (m_en[c])
        m_pre[c] = tk ? 0 : (m_pre[c] + 1) % 256;
      if (tk) begin
        if (m_count[c] != 0) m_count[c]--;
        else if (m_ar[c]) m_count[c] = m_reload[c];
        else m_en[c] = 0;
      end
    end
    if (acc && we) begin
      if (a == 16) begin
        m_flag &= ~dat_i[CH-1:0];
      end else if (a < 16 && a / 4 < CH) begin
        n = a / 4;
        case (a % 4)
          0: begin
            if (dat_i[0] && !was_en[n])
              m_pre[n] = 0;
            m_en[n] = dat_i[0];
            m_ar[n] = dat_i[1];
            m_ie[n] = dat_i[2];
            m_presc[n] = dat_i[15:8];
          end
          1: m_reload[n] = dat_i & MASK;
          2: begin
            m_count[n] = dat_i & MASK;
            m_pre[n] = 0;
          end
          default:
            if (PWM) m_cmp[n] = dat_i & MASK;
        endcase
      end
    end
    m_flag |= exs;
    m_ack = acc;
    m_irq = irq_n;
    m_pwm = pwm_n;
  endtask

  // monitor: per-cycle outputs, acks pop the scoreboard
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      check("ack", ack, m_ack);
      check("irq", irq, m_irq);
      check("pwm", pwm, m_pwm);
      for (int n = 0; n < CH; n++) begin
        irq_cnt[n] += int'(irq[n]);
        pwm_cnt[n] += int'(pwm[n]);
      end
      ack_cnt += int'(ack);
      if (ack) begin
        check("ack_expected", q.size() > 0, 1);
        if (q.size() > 0) begin
          e = q.pop_front();
          if (e.is_rd) check("rdata", dat_o, e.data);
        end
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    if (p_reset_n) model_step();
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) cyc();
  endtask

  task automatic bus(input int a, input bit w,
                     input logic [31:0] d);
    adr = 15'(int'(BASE) + a);
    we = w; dat_i = d; stb = 1'b1;
    cyc();
    stb = 1'b0; we = 1'b0;
    cyc();
  endtask

  task automatic clr_cnt();
    for (int n = 0; n < CH; n++) begin
      irq_cnt[n] = 0; pwm_cnt[n] = 0;
    end
    ack_cnt = 0;
  endtask

  initial begin
    int a;
    bit w;
    logic [31:0] d;
    p_reset_n = 1'b0;
    model_reset();
    clr_cnt();
    idle(3);
    p_reset_n = 1'b1;
    idle(2);

    for (int i = 0; i < 32; i++) bus(i, 0, 0);

    bus(1, 1, 3);
    bus(2, 1, 3);
    bus(0, 1, 32'h7);
    clr_cnt();
    idle(40);
    check("ch0_irq_period", irq_cnt[0], 10);
    bus(16, 0, 0);
    bus(0, 1, 0);
    bus(16, 1, 1);
    bus(16, 0, 0);

    bus(5, 1, 1);
    bus(6, 1, 1);
    clr_cnt();
    bus(4, 1, 32'h205);
    idle(15);
    check("ch1_single_irq", irq_cnt[1], 1);
    bus(4, 0, 0);
    bus(6, 0, 0);

    bus(16, 1, 3);
    bus(1, 1, 5);
    bus(2, 1, 1);
    bus(0, 1, 32'h3);
    bus(2, 1, 7);
    bus(2, 0, 0);
    bus(16, 0, 0);
    bus(0, 1, 0);
    bus(2, 1, 1);
    bus(16, 1, 3);
    bus(0, 1, 32'h3);
    bus(16, 1, 1);
    bus(0, 1, 0);
    bus(16, 0, 0);

    clr_cnt();
    adr = 15'(int'(BASE) + 32);
    we = 1'b1; dat_i = 32'hFFFF_FFFF;
    stb = 1'b1;
    idle(8);
    check("miss_no_ack", ack_cnt, 0);
    stb = 1'b0; we = 1'b0;
    cyc();
    for (int i = 0; i < 4; i++) bus(i, 0, 0);

    bus(1, 1, 9);
    bus(2, 1, 9);
    bus(3, 1, 3);
    bus(0, 1, 32'h3);
    idle(5);
    clr_cnt();
    idle(40);
    check("pwm_duty", pwm_cnt[0], PWM ? 12 : 0);
    bus(3, 0, 0);
    bus(0, 1, 0);

    for (int i = 0; i < 400; i++) begin
      a = $urandom_range(0, 19);
      w = 1'($urandom_range(0, 1));
      d = $urandom;
      if (a < 16 && a % 4 == 0) begin
        d = (d & 32'hFFFF_00F8)
          | ($urandom_range(0, 3) << 8)
          | $urandom_range(0, 7);
      end else if (a < 16 && $urandom_range(0, 7) != 0) begin
        d = $urandom_range(0, 12);
      end
      if (a == 19) begin
        adr = 15'(int'(BASE) + 40);
        stb = 1'b1;
        idle(3);
        stb = 1'b0;
        cyc();
      end else begin
        bus(a, w, d);
      end
      idle($urandom_range(0, 3));
    end

    adr = 15'(int'(BASE) + 2);
    we = 1'b0; stb = 1'b1;
    @(posedge clk);
    model_step();
    #2;
    p_reset_n = 1'b0;
    model_reset();
    stb = 1'b0;
    idle(2);
    p_reset_n = 1'b1;
    for (int i = 0; i < 18; i++) bus(i, 0, 0);

    idle(2);
    check("scoreboard_drained", q.size(), 0);
    $display("[TB] %0d tests run, %0d failed",
             tests, fails);
    $finish;
  end

endmodule
